// File: rtl/seq_mult_acc.sv
// Multi-cycle shift-add multiplier with optional two's-complement operands and
// accumulate-into-result mode; one result every WIDTH+2 cycles.
module seq_mult_acc #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 signed_mode,
    input  logic                 acc_mode,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product,
    output logic                 overflow
);

    localparam int PW = 2 * WIDTH;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        SIGN,
        DONE
    } state_t;

    state_t           state_reg;
    logic [PW-1:0]    mcand_reg;
    logic [PW-1:0]    partial_reg;
    logic [WIDTH-1:0] mplier_reg;
    logic [CNT_W-1:0] count_reg;
    logic             neg_reg;
    logic             acc_reg;
    logic             sgn_reg;
    logic [PW-1:0]    product_reg;
    logic             overflow_reg;
    logic             busy_reg;
    logic             done_reg;

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [PW-1:0]    result_next;
    logic [PW:0]      sum_wide;
    logic             wrap;

    assign busy     = busy_reg;
    assign done     = done_reg;
    assign product  = product_reg;
    assign overflow = overflow_reg;

    // Magnitudes wrap naturally: the most-negative operand maps to 2**(WIDTH-1).
    always_comb begin
        a_mag       = a;
        b_mag       = b;
        result_next = partial_reg;
        sum_wide    = '0;
        wrap        = 1'b0;
        if (signed_mode && a[WIDTH-1]) begin
            a_mag = ~a + WIDTH'(1);
        end
        if (signed_mode && b[WIDTH-1]) begin
            b_mag = ~b + WIDTH'(1);
        end
        if (neg_reg) begin
            result_next = ~partial_reg + PW'(1);
        end
        sum_wide = {1'b0, product_reg} + {1'b0, result_next};
        if (sgn_reg) begin
            wrap = (product_reg[PW-1] == result_next[PW-1]) &&
                   (sum_wide[PW-1] != product_reg[PW-1]);
        end else begin
            wrap = sum_wide[PW];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg    <= IDLE;
            mcand_reg    <= '0;
            partial_reg  <= '0;
            mplier_reg   <= '0;
            count_reg    <= '0;
            neg_reg      <= 1'b0;
            acc_reg      <= 1'b0;
            sgn_reg      <= 1'b0;
            product_reg  <= '0;
            overflow_reg <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE, DONE: begin
                    if (start) begin
                        mcand_reg   <= {{WIDTH{1'b0}}, a_mag};
                        mplier_reg  <= b_mag;
                        neg_reg     <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                        sgn_reg     <= signed_mode;
                        acc_reg     <= acc_mode;
                        partial_reg <= '0;
                        count_reg   <= '0;
                        busy_reg    <= 1'b1;
                        state_reg   <= RUN;
                    end else begin
                        state_reg <= IDLE;
                    end
                end
                RUN: begin
                    if (mplier_reg[0]) begin
                        partial_reg <= partial_reg + mcand_reg;
                    end
                    mcand_reg  <= mcand_reg << 1;
                    mplier_reg <= mplier_reg >> 1;
                    count_reg  <= count_reg + CNT_W'(1);
                    if (count_reg == CNT_W'(WIDTH - 1)) begin
                        state_reg <= SIGN;
                    end
                end
                SIGN: begin
                    if (acc_reg) begin
                        product_reg  <= sum_wide[PW-1:0];
                        overflow_reg <= wrap;
                    end else begin
                        product_reg  <= result_next;
                        overflow_reg <= 1'b0;
                    end
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b1;
                    state_reg <= DONE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mult_acc.sv
// Self-checking bench for seq_mult_acc (WIDTH=8): directed table, multi-cycle
// corner sequences, and randomized operations against an arithmetic model.
module tb_seq_mult_acc;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           start = 1'b0;
    logic [W-1:0]   a = '0;
    logic [W-1:0]   b = '0;
    logic           signed_mode = 1'b0;
    logic           acc_mode = 1'b0;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;
    logic           overflow;

    int checks = 0;
    int errors = 0;

    longint m_prev = 0;
    logic   m_ovf = 1'b0;

    seq_mult_acc #(.WIDTH(W), .CNT_W(5)) dut (
        .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
        .signed_mode(signed_mode), .acc_mode(acc_mode),
        .busy(busy), .done(done), .product(product), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic        sm;
        logic        am;
        logic [15:0] p;
        logic        o;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operand values.
    task automatic model(input logic [7:0] ma, input logic [7:0] mb, input logic sm, input logic am);
        longint pa, pb, rr, sp, sr, ss;
        pa = sm ? longint'($signed(ma)) : longint'(ma);
        pb = sm ? longint'($signed(mb)) : longint'(mb);
        rr = (pa * pb) & 64'hFFFF;
        if (am) begin
            if (sm) begin
                sp = (m_prev >= 32768) ? m_prev - 65536 : m_prev;
                sr = (rr >= 32768) ? rr - 65536 : rr;
                ss = sp + sr;
                m_ovf = (ss > 32767) || (ss < -32768);
            end else begin
                m_ovf = (m_prev + rr) > 65535;
            end
            m_prev = (m_prev + rr) & 64'hFFFF;
        end else begin
            m_prev = rr;
            m_ovf = 1'b0;
        end
    endtask

    task automatic do_op(input logic [7:0] va, input logic [7:0] vb, input logic sm, input logic am,
                         output logic [15:0] p, output logic o, output int lat, output int bc);
        @(negedge clk);
        a = va; b = vb; signed_mode = sm; acc_mode = am; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = $urandom; b = $urandom; signed_mode = $urandom; acc_mode = $urandom;
        lat = 0;
        bc = busy ? 1 : 0;
        while (!done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (busy) bc++;
        end
        p = product;
        o = overflow;
        $display("op a=%h b=%h signed=%b acc=%b -> product=%h overflow=%b latency=%0d", va, vb, sm, am, p, o, lat);
    endtask

    initial begin
        logic [15:0] p, p1, p2;
        logic        o;
        int          lat, bc, t1, t2;
        logic        bsy_after;
        logic        seen;

        vecs[0] = '{8'hFF, 8'hFF, 1'b0, 1'b0, 16'hFE01, 1'b0};
        vecs[1] = '{8'hFD, 8'h05, 1'b1, 1'b0, 16'hFFF1, 1'b0};
        vecs[2] = '{8'h80, 8'h80, 1'b1, 1'b0, 16'h4000, 1'b0};
        vecs[3] = '{8'hFF, 8'hFF, 1'b0, 1'b0, 16'hFE01, 1'b0};
        vecs[4] = '{8'h01, 8'hFF, 1'b0, 1'b1, 16'hFF00, 1'b0};
        vecs[5] = '{8'h02, 8'h80, 1'b0, 1'b1, 16'h0000, 1'b1};
        vecs[6] = '{8'h00, 8'h37, 1'b0, 1'b1, 16'h0000, 1'b0};
        vecs[7] = '{8'h7F, 8'h7F, 1'b1, 1'b0, 16'h3F01, 1'b0};
        vecs[8] = '{8'h7F, 8'h7F, 1'b1, 1'b1, 16'h7E02, 1'b0};
        vecs[9] = '{8'h7F, 8'h7F, 1'b1, 1'b1, 16'hBD03, 1'b1};

        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("reset_product", product, 0);
        check("reset_overflow", overflow, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);

        for (int i = 0; i < 10; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].sm, vecs[i].am, p, o, lat, bc);
            check($sformatf("vec%0d_product", i), p, vecs[i].p);
            check($sformatf("vec%0d_overflow", i), o, vecs[i].o);
            check($sformatf("vec%0d_latency", i), lat, W + 1);
            check($sformatf("vec%0d_busy_cycles", i), bc, W + 1);
        end
        m_prev = 16'hBD03;

        // Back-to-back: start held high through DONE.
        @(negedge clk);
        a = 8'd3; b = 8'd4; signed_mode = 1'b0; acc_mode = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        a = 8'd5; b = 8'd6;
        t1 = -1; t2 = -1; p1 = '0; p2 = '0; bsy_after = 1'b0;
        for (int k = 1; k <= 40 && t2 < 0; k++) begin
            @(posedge clk); #1;
            if (done) begin
                if (t1 < 0) begin
                    t1 = k; p1 = product;
                end else begin
                    t2 = k; p2 = product; start = 1'b0;
                end
            end
            if (t1 > 0 && k == t1 + 1) bsy_after = busy;
        end
        start = 1'b0;
        $display("b2b first_done=%0d product=%h second_done=%0d product=%h", t1, p1, t2, p2);
        check("b2b_first_time", t1, W + 1);
        check("b2b_first_product", p1, 16'h000C);
        check("b2b_gap", t2 - t1, W + 2);
        check("b2b_second_product", p2, 16'h001E);
        check("b2b_busy_no_idle", bsy_after, 1);
        m_prev = 16'h001E;

        // Start pulsed mid-run is ignored.
        @(negedge clk);
        a = 8'd10; b = 8'd11; signed_mode = 1'b0; acc_mode = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0; seen = 1'b0;
        while (!done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 4) begin
                a = 8'd2; b = 8'd2; acc_mode = 1'b1; start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        $display("ignored_start product=%h latency=%0d", product, lat);
        check("ignore_latency", lat, W + 1);
        check("ignore_product", product, 16'h006E);
        m_prev = 16'h006E;

        // Reset mid-run aborts with no trace.
        @(negedge clk);
        a = 8'd9; b = 8'd9; signed_mode = 1'b0; acc_mode = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_product", product, 0);
        check("abort_overflow", overflow, 0);
        seen = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done) seen = 1'b1;
        end
        $display("abort no_done_seen=%b", !seen);
        check("abort_no_done", seen, 0);
        m_prev = 0;
        do_op(8'd3, 8'd4, 1'b0, 1'b1, p, o, lat, bc);
        model(8'd3, 8'd4, 1'b0, 1'b1);
        check("post_abort_product", p, m_prev);
        check("post_abort_overflow", o, m_ovf);
        check("post_abort_latency", lat, W + 1);

        for (int i = 0; i < 150; i++) begin
            logic [7:0] ra, rb;
            logic rs, rm;
            ra = $urandom;
            rb = $urandom;
            rs = $urandom;
            rm = $urandom;
            if (i % 16 == 0) ra = 8'h80;
            if (i % 16 == 1) rb = 8'h00;
            do_op(ra, rb, rs, rm, p, o, lat, bc);
            model(ra, rb, rs, rm);
            check($sformatf("rand%0d_product", i), p, m_prev);
            check($sformatf("rand%0d_overflow", i), o, m_ovf);
            check($sformatf("rand%0d_latency", i), lat, W + 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
